cache_refill: RTL and testbench
===============================

# cache_refill

Miss handler between the data cache and the memory port. When the cache signals a miss, the block optionally writes back the dirty victim line, fetches the missed line from memory one word per handshake, and assembles it. It then presents the full line to the cache for a single-cycle fill, which sets the cache line's tag and valid bit and clears its dirty bit.

## Interface
- ARCH_BITS, 32, word and address width.
- CACHE_LINE_SIZE, 128, line width in bits; WORDS = CACHE_LINE_SIZE/ARCH_BITS (power of two, ≥2).
- OFFSET_BITS, 4, log2(CACHE_LINE_SIZE/8); byte-offset field cleared to form line addresses.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- missReq  in  1  cache miss pending; level, held until fillValid.
- missAddr  in  ARCH_BITS  address that missed.
- victimDirty  in  1  indexed line is valid and dirty.
- victimAddr  in  ARCH_BITS  line address of the victim.
- victimLine  in  CACHE_LINE_SIZE  victim data.
- busy  out  1  state ≠ IDLE.
- fillValid  out  1  one-cycle pulse; fillLine/fillAddr valid.
- fillAddr  out  ARCH_BITS  line-aligned miss address.
- fillLine  out  CACHE_LINE_SIZE  fetched line; word k at bits [(k+1)*ARCH_BITS-1 -: ARCH_BITS].
- memReq  out  1  memory request.
- memWE  out  1  1 = write beat, 0 = read beat.
- memAddr  out  ARCH_BITS  beat byte address.
- memWData  out  ARCH_BITS  write data.
- memAck  in  1  beat completes at the posedge where memReq && memAck.
- memRData  in  ARCH_BITS  read data; valid with memAck on read beats.

## Operation
- States: IDLE, WB, FETCH, FILL.
- IDLE: on missReq, register lineBase = missAddr with low OFFSET_BITS zeroed, victim address, victim line, and victimDirty. Go to WB if victimDirty, else FETCH. beat := 0.
- WB: memReq=1, memWE=1, memAddr = victimBase + beat*(ARCH_BITS/8), memWData = victim word[beat]. Each ack increments beat. The ack on beat WORDS-1 sets beat := 0 and goes to FETCH.
- FETCH: memReq=1, memWE=0, memAddr = lineBase + beat*(ARCH_BITS/8). Each ack writes memRData into buffer word[beat] and increments beat. The ack on beat WORDS-1 goes to FILL.
- FILL: fillValid=1, memReq=0. Go to IDLE next cycle.
- Beat counter is log2(WORDS) bits. Addresses wrap modulo 2^ARCH_BITS, and no carry is checked.
- memReq, memWE, memAddr, and memWData stay stable until acked. A new beat's request is presented the cycle after the previous ack, with memReq held high continuously across beats.
- memAck while memReq=0 is ignored. memRData is ignored on write beats.
- missReq and all cache inputs are ignored outside IDLE. Captured values are used throughout the miss.
- fillAddr and fillLine hold their last value until the next FILL.

## Timing
- Reset values: busy=0, fillValid=0, fillAddr=0, fillLine=0, memReq=0, memWE=0, memAddr=0, memWData=0, state IDLE, beat 0.
- Reset mid-miss takes effect immediately: memReq drops asynchronously, and partial data is discarded with no fill.
- missReq sampled at edge T → busy=1 and memReq=1 from T+1.
- Clean miss with ack every cycle: read acks at T+1..T+WORDS, fillValid during T+WORDS+1, IDLE at T+WORDS+2.
- Dirty miss adds WORDS cycles.
- Each wait cycle (memReq without memAck) adds one cycle.
- The cache updates at the fillValid edge, so missReq is low when IDLE is re-entered. If missReq is still high there (a new miss), it starts a new refill back-to-back.

## Configuration
- CACHE_REFILL_WRITEBACK_EN defined: dirty victims are written back via the WB state as above.
- Not defined: the WB state is absent and victimDirty, victimAddr, and victimLine are unused. Every miss goes IDLE→FETCH, and memWE is constant 0.

## Test plan
- Reset, then idle: all outputs 0. Assert rst in FETCH beat 2: memReq drops without waiting for clk, and fillValid never pulses.
- Clean miss, missAddr=0x0000_1234, zero-wait memory returning addr^0xA5A5_0000: read addresses 0x1230, 0x1234, 0x1238, 0x123C. Then fillAddr=0x1230 and fillLine={0xA5A5123C, 0xA5A51238, 0xA5A51234, 0xA5A51230}, with fillValid exactly 5 cycles after the missReq edge.
- Dirty miss (macro defined), victimAddr=0x0000_0200, victimLine={0x44, 0x33, 0x22, 0x11}: write beats 0x200←0x11, 0x204←0x22, 0x208←0x33, 0x20C←0x44, then 4 read beats. fillValid comes 9 cycles after the request.
- Same dirty miss with the macro undefined: no write beats, and fillValid comes 5 cycles after the request.
- Memory with 2 wait states per beat: memAddr and memWData stay stable while unacked, and fillValid comes 13 cycles after a clean request.
- Toggle missAddr and missReq during FETCH: no effect on beat addresses. Hold missReq high through IDLE: a second refill starts immediately.

Source files
------------

// File: rtl/cache_refill.sv
`timescale 1ns/1ps
// cache_refill
//   Miss handler between the data cache and the memory port. On a miss it
//   optionally writes back the dirty victim line, then fetches the missed
//   line one word per memory handshake and presents the assembled line to
//   the cache as a single-cycle fill pulse.
//
//   Optional feature macro: CACHE_REFILL_WRITEBACK_EN
//     defined   - dirty victims are written back (WB state) before the fetch.
//     undefined - no write-back; victim inputs unused, memWE is always 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   missReq         miss pending (level, held until fillValid)
//   missAddr        address that missed
//   victimDirty     indexed line is valid and dirty
//   victimAddr      line address of the victim
//   victimLine      victim line data
//   busy            refill in progress
//   fillValid       one-cycle pulse, fillAddr/fillLine valid
//   fillAddr        line-aligned miss address
//   fillLine        fetched line, word k at [(k+1)*ARCH_BITS-1 -: ARCH_BITS]
//   memReq/memWE    memory request / write beat
//   memAddr         beat byte address
//   memWData        write data
//   memAck          beat completes on posedge with memReq && memAck
//   memRData        read data, valid with memAck on read beats
module cache_refill #(
  parameter int ARCH_BITS       = 32,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int OFFSET_BITS     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       missReq,
  input  logic [ARCH_BITS-1:0]       missAddr,
  input  logic                       victimDirty,
  input  logic [ARCH_BITS-1:0]       victimAddr,
  input  logic [CACHE_LINE_SIZE-1:0] victimLine,
  output logic                       busy,
  output logic                       fillValid,
  output logic [ARCH_BITS-1:0]       fillAddr,
  output logic [CACHE_LINE_SIZE-1:0] fillLine,
  output logic                       memReq,
  output logic                       memWE,
  output logic [ARCH_BITS-1:0]       memAddr,
  output logic [ARCH_BITS-1:0]       memWData,
  input  logic                       memAck,
  input  logic [ARCH_BITS-1:0]       memRData
);

  localparam int WORDS  = CACHE_LINE_SIZE / ARCH_BITS;
  localparam int BEAT_W = $clog2(WORDS);
  localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(WORDS - 1);
  localparam logic [ARCH_BITS-1:0] WORD_BYTES = ARCH_BITS'(ARCH_BITS / 8);

  typedef enum logic [1:0] {IDLE, WB, FETCH, FILL} state_t;

  state_t                     state;
  logic [BEAT_W-1:0]          beat;
  logic [ARCH_BITS-1:0]       lineBase;
  logic [ARCH_BITS-1:0]       missBase;
  logic [CACHE_LINE_SIZE-1:0] lineBuf;
  logic [CACHE_LINE_SIZE-1:0] nextLine;
  logic                       unusedBits;

  assign missBase = {missAddr[ARCH_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // Line buffer with the current read beat merged in; the final beat's word
  // goes straight into fillLine so fillLine only changes when a fill starts.
  always_comb begin
    nextLine = lineBuf;
    nextLine[beat*ARCH_BITS +: ARCH_BITS] = memRData;
  end

`ifdef CACHE_REFILL_WRITEBACK_EN
  logic [CACHE_LINE_SIZE-1:0] victimBuf;

  function automatic logic [ARCH_BITS-1:0] victimWord(
    input logic [CACHE_LINE_SIZE-1:0] line,
    input logic [BEAT_W-1:0]          idx
  );
    return line[idx*ARCH_BITS +: ARCH_BITS];
  endfunction

  assign unusedBits = ^missAddr[OFFSET_BITS-1:0];
`else
  assign unusedBits = ^{missAddr[OFFSET_BITS-1:0], victimDirty, victimAddr, victimLine};
`endif

  // Control FSM; every memory/cache-facing output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      lineBase  <= '0;
      busy      <= 1'b0;
      fillValid <= 1'b0;
      fillAddr  <= '0;
      fillLine  <= '0;
      memReq    <= 1'b0;
      memWE     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
    end else begin
      fillValid <= 1'b0;
      case (state)
        IDLE: begin
          if (missReq) begin
            beat     <= '0;
            lineBase <= missBase;
            busy     <= 1'b1;
            memReq   <= 1'b1;
`ifdef CACHE_REFILL_WRITEBACK_EN
            if (victimDirty) begin
              state    <= WB;
              memWE    <= 1'b1;
              memAddr  <= victimAddr;
              memWData <= victimWord(victimLine, '0);
            end else begin
              state   <= FETCH;
              memWE   <= 1'b0;
              memAddr <= missBase;
            end
`else
            state   <= FETCH;
            memAddr <= missBase;
`endif
          end
        end
`ifdef CACHE_REFILL_WRITEBACK_EN
        WB: begin
          if (memAck) begin
            if (beat == LAST_BEAT) begin
              beat    <= '0;
              state   <= FETCH;
              memWE   <= 1'b0;
              memAddr <= lineBase;
            end else begin
              beat     <= beat + 1'b1;
              memAddr  <= memAddr + WORD_BYTES;
              memWData <= victimWord(victimBuf, beat + 1'b1);
            end
          end
        end
`endif
        FETCH: begin
          if (memAck) begin
            if (beat == LAST_BEAT) begin
              beat      <= '0;
              state     <= FILL;
              memReq    <= 1'b0;
              fillValid <= 1'b1;
              fillAddr  <= lineBase;
              fillLine  <= nextLine;
            end else begin
              beat    <= beat + 1'b1;
              memAddr <= memAddr + WORD_BYTES;
            end
          end
        end
        FILL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          memReq <= 1'b0;
        end
      endcase
    end
  end

  // Data capture; contents are fully rewritten by every miss, so no reset.
  always_ff @(posedge clk) begin
    if (state == FETCH && memAck) begin
      lineBuf <= nextLine;
    end
`ifdef CACHE_REFILL_WRITEBACK_EN
    if (state == IDLE && missReq) begin
      victimBuf <= victimLine;
    end
`endif
  end

endmodule

// File: tb/tb_cache_refill.sv
`timescale 1ns/1ps
// Testbench for cache_refill: scoreboard of expected memory beats and fills,
// a memory responder with programmable wait states, and miss-latency checks.
module tb_cache_refill;

  localparam logic [31:0] RKEY = 32'hA5A5_0000;
`ifdef CACHE_REFILL_WRITEBACK_EN
  localparam int DIRTY_LAT      = 9;
  localparam int DIRTY_WAIT_LAT = 25;
`else
  localparam int DIRTY_LAT      = 5;
  localparam int DIRTY_WAIT_LAT = 13;
`endif

  logic         clk;
  logic         rst;
  logic         missReq;
  logic [31:0]  missAddr;
  logic         victimDirty;
  logic [31:0]  victimAddr;
  logic [127:0] victimLine;
  logic         busy;
  logic         fillValid;
  logic [31:0]  fillAddr;
  logic [127:0] fillLine;
  logic         memReq;
  logic         memWE;
  logic [31:0]  memAddr;
  logic [31:0]  memWData;
  logic         memAck;
  logic [31:0]  memRData;

  cache_refill dut (
    .clk        (clk),
    .rst        (rst),
    .missReq    (missReq),
    .missAddr   (missAddr),
    .victimDirty(victimDirty),
    .victimAddr (victimAddr),
    .victimLine (victimLine),
    .busy       (busy),
    .fillValid  (fillValid),
    .fillAddr   (fillAddr),
    .fillLine   (fillLine),
    .memReq     (memReq),
    .memWE      (memWE),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memAck     (memAck),
    .memRData   (memRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] line;
  } fill_t;

  beat_t expBeats[$];
  fill_t expFills[$];
  int    nCompared   = 0;
  int    nMismatched = 0;
  int    waitStates  = 0;
  logic  idleAck     = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushRead(input logic [31:0] base, input logic withFill);
    logic [127:0] line;
    line = '0;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = base + 32'(4 * k);
      expBeats.push_back('{we: 1'b0, addr: a, data: a ^ RKEY});
      line[k*32 +: 32] = a ^ RKEY;
    end
    if (withFill) expFills.push_back('{addr: base, line: line});
  endtask

  task automatic pushWrite(input logic [31:0] vAddr, input logic [127:0] vLine);
    for (int k = 0; k < 4; k++) begin
      expBeats.push_back('{we: 1'b1, addr: vAddr + 32'(4 * k), data: vLine[k*32 +: 32]});
    end
  endtask

  // Memory responder and output monitor, sampling on the falling edge.
  initial begin : memModel
    int          waitCnt;
    logic [31:0] heldAddr;
    logic [31:0] heldData;
    beat_t       b;
    fill_t       f;
    waitCnt  = 0;
    heldAddr = '0;
    heldData = '0;
    memAck   = 1'b0;
    memRData = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        memAck  = 1'b0;
        waitCnt = 0;
      end else begin
        if (fillValid) begin
          if (expFills.size() == 0) chk("fillUnexpected", 1, 0);
          else begin
            f = expFills.pop_front();
            chk("fillAddr", fillAddr, f.addr);
            chk("fillLine", fillLine, f.line);
          end
        end
        if (!memReq) begin
          memAck  = idleAck;
          waitCnt = 0;
        end else begin
          if (waitCnt == 0) begin
            heldAddr = memAddr;
            heldData = memWData;
          end else begin
            chk("stableAddr", memAddr, heldAddr);
            if (memWE) chk("stableWData", memWData, heldData);
          end
          if (waitCnt == waitStates) begin
            if (expBeats.size() == 0) chk("beatUnexpected", 1, 0);
            else begin
              b = expBeats.pop_front();
              chk("beatWE", memWE, b.we);
              chk("beatAddr", memAddr, b.addr);
              if (b.we) chk("beatWData", memWData, b.data);
            end
            memAck   = 1'b1;
            memRData = memAddr ^ RKEY;
            waitCnt  = 0;
          end else begin
            memAck = 1'b0;
            waitCnt++;
          end
        end
      end
    end
  end

  // Called on a falling edge; issues a miss and measures edges until fillValid.
  task automatic doMiss(input string tag, input logic [31:0] addr, input logic dirty,
                        input logic [31:0] vAddr, input logic [127:0] vLine,
                        input int expLat, input bit toggle, input bit hold);
    int cycles;
    bit done;
    missAddr    = addr;
    victimDirty = dirty;
    victimAddr  = vAddr;
    victimLine  = vLine;
    missReq     = 1'b1;
`ifdef CACHE_REFILL_WRITEBACK_EN
    if (dirty) pushWrite(vAddr, vLine);
`endif
    pushRead({addr[31:4], 4'h0}, 1'b1);
    cycles = 0;
    done   = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        chk({tag, ":busy"}, busy, 1);
        chk({tag, ":memReq"}, memReq, 1);
      end
      if (fillValid) done = 1;
      else if (toggle) begin
        missAddr    = $urandom;
        missReq     = cycles[0];
        victimDirty = ~victimDirty;
        victimAddr  = $urandom;
        victimLine  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    chk({tag, ":latency"}, cycles, expLat);
    if (!hold) missReq = 1'b0;
    @(negedge clk);
    chk({tag, ":idle"}, busy, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit found;
    rst         = 1'b1;
    missReq     = 1'b0;
    missAddr    = '0;
    victimDirty = 1'b0;
    victimAddr  = '0;
    victimLine  = '0;
    repeat (3) @(negedge clk);
    chk("rst:busy", busy, 0);
    chk("rst:fillValid", fillValid, 0);
    chk("rst:fillAddr", fillAddr, 0);
    chk("rst:fillLine", fillLine, 0);
    chk("rst:memReq", memReq, 0);
    chk("rst:memWE", memWE, 0);
    chk("rst:memAddr", memAddr, 0);
    chk("rst:memWData", memWData, 0);

    // Idle with stray acks: nothing must start.
    rst     = 1'b0;
    idleAck = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle:busy", busy, 0);
    chk("idle:memReq", memReq, 0);
    chk("idle:fillValid", fillValid, 0);
    idleAck = 1'b0;

    doMiss("clean", 32'h0000_1234, 1'b0, '0, '0, 5, 0, 0);
    @(negedge clk);
    chk("holdFillAddr", fillAddr, 32'h0000_1230);
    chk("holdFillLine", fillLine, {32'hA5A5123C, 32'hA5A51238, 32'hA5A51234, 32'hA5A51230});

    doMiss("dirty", 32'h0000_5678, 1'b1, 32'h0000_0200,
           {32'h44, 32'h33, 32'h22, 32'h11}, DIRTY_LAT, 0, 0);
    doMiss("wrap", 32'hFFFF_FFF4, 1'b1, 32'hFFFF_FFF8,
           {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, DIRTY_LAT, 0, 0);

    waitStates = 2;
    doMiss("wait", 32'hABCD_EF0C, 1'b0, '0, '0, 13, 0, 0);
    doMiss("waitDirty", 32'h0000_3300, 1'b1, 32'h0000_0400,
           {32'h1111_4444, 32'h1111_3333, 32'h1111_2222, 32'h1111_1111}, DIRTY_WAIT_LAT, 0, 0);
    waitStates = 0;

    doMiss("toggle", 32'h0000_4448, 1'b0, '0, '0, 5, 1, 0);
    doMiss("b2bFirst", 32'h0000_7004, 1'b0, '0, '0, 5, 0, 1);
    doMiss("b2bSecond", 32'h0000_8010, 1'b0, '0, '0, 5, 0, 0);

    // Reset while fetch beat 2 is being presented.
    missAddr    = 32'h0000_9000;
    victimDirty = 1'b0;
    missReq     = 1'b1;
    pushRead(32'h0000_9000, 1'b0);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (memReq && memAddr == 32'h0000_9008) found = 1;
    end
    chk("rstMid:reachBeat2", found, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstMid:memReqAsync", memReq, 0);
    chk("rstMid:busyAsync", busy, 0);
    missReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstMid:noFill", fillValid, 0);
    end
    chk("rstMid:beatsLeft", expBeats.size(), 1);
    expBeats.delete();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postRst:noFill", fillValid, 0);
      chk("postRst:memReq", memReq, 0);
    end

    doMiss("afterRst", 32'h0000_1234, 1'b0, '0, '0, 5, 0, 0);

    repeat (2) @(negedge clk);
    chk("end:fillsLeft", expFills.size(), 0);
    chk("end:beatsLeft", expBeats.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
